// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM two-port arbiter: FSM encoding, port
// indices and command timing.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Requester indices into req/we/ack.
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  // Width in cycles of the mem_read / mem_write command pulse.
  localparam int CMD_PULSE_CYCLES = 1;

  // PSRAM controller byte-address width.
  localparam int MEM_ADDR_W = 22;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On a tie the port that did not win last time
// gets the grant; the last-winner register only moves when the grant is
// actually taken (accept).
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // Index of the last winner; reset to 1 so port 0 wins the first tie.
  logic last_q;

  // One-hot grant: single requester wins outright, a tie goes to ~last_q.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of every accepted grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-requester byte-access arbiter in front of a 16-bit PSRAM controller.
// One access at a time: grant, one-cycle command pulse, wait for the
// controller busy to rise and fall (or time out), then a one-cycle ack.
//
// Handshake: a requester raises req[i] with we/addr/wdata valid and holds it
// until ack[i]; the inputs are latched at grant, so anything after that,
// including dropping req, has no effect on the access in flight.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int              ADDR_W  = 19,
  parameter logic [21:0]     BASE    = 22'h000000,
  parameter int              TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic [1:0]        ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [21:0]       mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, next_state;
  logic [1:0]        grant;
  logic              accept;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [1:0]        gnt_q;
  logic              err_q;
  logic [7:0]        rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              issue_done;
  logic              timeout_hit;

  // Never start while the controller is still busy (e.g. from an access
  // that was cut short by reset).
  assign accept      = (state == ST_IDLE) && (req != 2'b00) && !mem_busy;
  assign issue_done  = (cnt == CNT_W'(CMD_PULSE_CYCLES - 1));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; busy rising wins over a timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept) next_state = ST_ISSUE;
      ST_ISSUE:   if (issue_done) next_state = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (mem_busy) begin
          next_state = ST_WAIT_LO;
        end else if (timeout_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_WAIT_LO: if (!mem_busy) next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    ack            = (state == ST_DONE) ? gnt_q : 2'b00;
    err            = (state == ST_DONE) && err_q;
    mem_read       = (state == ST_ISSUE) && !we_q;
    mem_write      = (state == ST_ISSUE) && we_q;
    mem_byte_write = mem_write;
  end

  // Cycle counter for the command pulse and the busy-rise timeout; cleared
  // on every state change so each timed state starts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if ((state == ST_ISSUE) || (state == ST_WAIT_HI)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Request latch at grant, timeout flag and read-byte capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        gnt_q <= grant;
        err_q <= 1'b0;
        if (grant[PORT_DMA]) begin
          we_q    <= we[PORT_DMA];
          addr_q  <= addr1;
          wdata_q <= wdata1;
        end else begin
          we_q    <= we[PORT_CPU];
          addr_q  <= addr0;
          wdata_q <= wdata0;
        end
      end
      if ((state == ST_WAIT_HI) && !mem_busy && timeout_hit) begin
        err_q <= 1'b1;
      end
      if ((state == ST_WAIT_LO) && !mem_busy && !we_q) begin
        rdata_q <= addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];
      end
    end
  end

  // Address and data are pure functions of the latched request, so they stay
  // stable for the whole access; the add wraps modulo 2^22.
  assign mem_addr  = BASE + MEM_ADDR_W'(addr_q);
  assign mem_din   = {wdata_q, wdata_q};
  assign rdata     = rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a simple busy-pulse controller model.
module tb_psram_arbiter;
  import psram_pkg::*;

  // Clock and reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]  req, we;
  logic [18:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic [15:0] mem_dout;
  logic        mem_busy;

  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        err, mem_read, mem_write, mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [2:0]  dbg_state;

  logic [1:0]  w_ack;
  logic [7:0]  w_rdata;
  logic        w_err, w_mem_read, w_mem_write, w_mem_byte_write;
  logic [21:0] w_mem_addr;
  logic [15:0] w_mem_din;
  logic [2:0]  w_dbg_state;

  psram_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .dbg_state(dbg_state)
  );

  // Second instance with a high BASE, sharing all inputs, to see the wrap.
  psram_arbiter #(.BASE(22'h3FFFF0)) dut_w (
    .clock(clock), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(w_ack), .rdata(w_rdata), .err(w_err),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_byte_write(w_mem_byte_write),
    .mem_addr(w_mem_addr), .mem_din(w_mem_din), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .dbg_state(w_dbg_state)
  );

  // Controller model: busy for bfm_len cycles after each command pulse.
  logic bfm_respond = 1'b1;
  logic bfm_hold    = 1'b0;
  int   bfm_len     = 6;
  int   busy_left   = 0;

  always @(posedge clock) begin
    if ((mem_read || mem_write) && bfm_respond) begin
      busy_left <= bfm_len;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign mem_busy = bfm_hold || (busy_left != 0);

  // Monitor: command, ack and overlap counts.
  int rd_cnt = 0, wr_cnt = 0, ack_cnt = 0, overlap_cnt = 0;
  always @(negedge clock) begin
    if (mem_read)  rd_cnt  <= rd_cnt + 1;
    if (mem_write) wr_cnt  <= wr_cnt + 1;
    if (ack != 2'b00) ack_cnt <= ack_cnt + 1;
    if ((mem_read && mem_write) || ((mem_read || mem_write) && mem_busy))
      overlap_cnt <= overlap_cnt + 1;
  end

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: bounded waits for a command pulse or an ack.
  task automatic wait_cmd(input string tag, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (mem_read || mem_write) seen = 1'b1;
    end
    check({tag, "_cmd_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (ack != 2'b00) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  int cyc;
  int ack_before;

  initial begin
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = 8'h00; wdata1 = 8'h00; mem_dout = 16'h0000;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ack",   32'(ack), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_cmd",   32'({mem_read, mem_write}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    // Busy already high in IDLE: no issue until it drops; then the port-0 read
    bfm_hold = 1'b1; we = 2'b00; addr0 = 19'h00001; mem_dout = 16'hBEEF; req = 2'b01;
    repeat (5) @(negedge clock);
    check("busy_hold_state", 32'(dbg_state), 32'(ST_IDLE));
    check("busy_hold_no_rd", 32'(rd_cnt), 32'd0);
    bfm_hold = 1'b0;
    wait_cmd("rd0", cyc);
    check("rd0_mem_read",  32'(mem_read), 32'd1);
    check("rd0_mem_write", 32'(mem_write), 32'd0);
    check("rd0_mem_addr",  32'(mem_addr), 32'h000001);
    check("rd0_wrap_addr", 32'(w_mem_addr), 32'h3FFFF1);
    wait_ack("rd0", 50, cyc);
    check("rd0_latency", 32'(cyc), 32'd8);
    check("rd0_ack",     32'(ack), 32'h1);
    check("rd0_err",     32'(err), 32'h0);
    check("rd0_rdata",   32'(rdata), 32'hBE);
    req = 2'b00;
    @(negedge clock);
    check("rd0_ack_pulse", 32'(ack), 32'h0);
    check("rd0_rd_cnt",    32'(rd_cnt), 32'd1);
    check("rd0_rdata_hold", 32'(rdata), 32'hBE);

    // Port-1 write; inputs changed after issue must not leak through
    we = 2'b10; addr1 = 19'h7FFFE; wdata1 = 8'h5A; req = 2'b10;
    wait_cmd("wr1", cyc);
    check("wr1_mem_write", 32'(mem_write), 32'd1);
    check("wr1_mem_read",  32'(mem_read), 32'd0);
    check("wr1_byte_wr",   32'(mem_byte_write), 32'd1);
    check("wr1_mem_din",   32'(mem_din), 32'h5A5A);
    check("wr1_mem_addr",  32'(mem_addr), 32'h07FFFE);
    wdata1 = 8'h11; addr1 = 19'h00000; we = 2'b00;
    wait_ack("wr1", 50, cyc);
    check("wr1_ack",        32'(ack), 32'h2);
    check("wr1_err",        32'(err), 32'h0);
    check("wr1_rdata_keep", 32'(rdata), 32'hBE);
    check("wr1_din_stable", 32'(mem_din), 32'h5A5A);
    check("wr1_addr_stable", 32'(mem_addr), 32'h07FFFE);
    req = 2'b00;

    // Both ports held: grants alternate 0,1,0,1 (last winner was port 1)
    we = 2'b00; addr0 = 19'h00010; addr1 = 19'h00011; mem_dout = 16'hA55A; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr", 50, cyc);
      check("rr_ack",   32'(ack), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rdata", 32'(rdata), (i % 2 == 0) ? 32'h5A : 32'hA5);
    end
    req = 2'b00;
    repeat (3) @(negedge clock);
    check("rr_overlap", 32'(overlap_cnt), 32'd0);
    check("rr_rd_cnt",  32'(rd_cnt), 32'd5);
    check("rr_wr_cnt",  32'(wr_cnt), 32'd1);

    // Address wrap on the high-BASE instance; req dropped before ack
    addr0 = 19'h00020; mem_dout = 16'h1234; req = 2'b01;
    wait_cmd("wrap", cyc);
    check("wrap_mem_addr", 32'(mem_addr), 32'h000020);
    check("wrap_w_addr",   32'(w_mem_addr), 32'h000010);
    req = 2'b00;
    wait_ack("drop", 50, cyc);
    check("drop_ack",   32'(ack), 32'h1);
    check("drop_rdata", 32'(rdata), 32'h34);

    // Controller never goes busy: timeout after TIMEOUT cycles in WAIT_HI
    bfm_respond = 1'b0; addr0 = 19'h00003; mem_dout = 16'hFFFF; req = 2'b01;
    wait_cmd("tmo", cyc);
    req = 2'b00;
    wait_ack("tmo", 400, cyc);
    check("tmo_cycles", 32'(cyc), 32'd256);
    check("tmo_ack",    32'(ack), 32'h1);
    check("tmo_err",    32'(err), 32'h1);
    check("tmo_rdata",  32'(rdata), 32'h34);
    @(negedge clock);
    check("tmo_err_pulse", 32'(err), 32'h0);
    bfm_respond = 1'b1;

    // Reset in WAIT_LO, then a port-1 read that must wait out the busy tail
    addr0 = 19'h00005; mem_dout = 16'h0000; req = 2'b01;
    wait_cmd("rstmid", cyc);
    req = 2'b00;
    repeat (2) @(negedge clock);
    check("rstmid_state", 32'(dbg_state), 32'(ST_WAIT_LO));
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_ack",   32'(ack), 32'h0);
    check("rstmid_err",   32'(err), 32'h0);
    check("rstmid_cmd",   32'({mem_read, mem_write, mem_byte_write}), 32'h0);
    check("rstmid_rdata", 32'(rdata), 32'h00);
    check("rstmid_addr",  32'(mem_addr), 32'h000000);
    check("rstmid_din",   32'(mem_din), 32'h0000);
    check("rstmid_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    ack_before = ack_cnt;
    reset = 1'b0;
    we = 2'b00; addr1 = 19'h00021; mem_dout = 16'hC33C; req = 2'b10;
    wait_cmd("post", cyc);
    check("post_wait_busy", 32'(cyc), 32'd5);
    check("post_no_ack",    32'(ack_cnt), 32'(ack_before));
    check("post_mem_addr",  32'(mem_addr), 32'h000021);
    wait_ack("post", 50, cyc);
    check("post_ack",   32'(ack), 32'h2);
    check("post_err",   32'(err), 32'h0);
    check("post_rdata", 32'(rdata), 32'hC3);
    req = 2'b00;
    repeat (2) @(negedge clock);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
